// File: rtl/rnd_feed_pkg.sv
// Shared constants and FSM state type for the seedable LFSR randomness feed.
package rnd_feed_pkg;
  localparam int LFSR_LEN = 64;
  localparam int SEED_W   = 32;
  localparam int TAP0     = 63;
  localparam int TAP1     = 62;
  localparam int TAP2     = 60;
  localparam int TAP3     = 59;

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } feed_state_e;
endpackage

// File: rtl/rnd_lfsr_step.sv
// Combinational NSTEP-fold unroll of the Fibonacci LFSR x^64+x^63+x^61+x^60+1.
module rnd_lfsr_step
  import rnd_feed_pkg::*;
#(
  parameter int NSTEP = 1
) (
  input  logic [LFSR_LEN-1:0] cur,
  output logic [LFSR_LEN-1:0] nxt
);
  logic [NSTEP:0][LFSR_LEN-1:0] chain;

  assign chain[0] = cur;

  for (genvar i = 0; i < NSTEP; i++) begin : g_step
    assign chain[i+1] = {chain[i][LFSR_LEN-2:0],
                         chain[i][TAP0] ^ chain[i][TAP1] ^ chain[i][TAP2] ^ chain[i][TAP3]};
  end

  assign nxt = chain[NSTEP];
endmodule

// File: rtl/rnd_lfsr_feed.sv
// Seedable LFSR randomness source: two-word seed load, warm-up discard, then
// NRND fresh bits per enabled cycle for a masked AND gadget's rnd port.
module rnd_lfsr_feed
  import rnd_feed_pkg::*;
#(
  parameter int d      = 2,
  parameter int NRND   = d * (d - 1),
  parameter int WARMUP = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEED_W-1:0] seed_in,
  input  logic              seed_valid,
  output logic              seed_ready,
  input  logic              en,
  output logic [NRND-1:0]   rnd,
  output logic              rnd_valid
);
  localparam int CW = $clog2(WARMUP + 1);

  feed_state_e         state;
  logic                wc;
  logic [CW-1:0]       wcnt;
  logic [LFSR_LEN-1:0] lfsr;
  logic [LFSR_LEN-1:0] stepped;
  logic [LFSR_LEN-1:0] shifted;

  // One unrolled NRND-step block serves both the warm-up and the run advance.
  rnd_lfsr_step #(.NSTEP(NRND)) u_step (
    .cur (lfsr),
    .nxt (stepped)
  );

  assign shifted = {lfsr[LFSR_LEN-SEED_W-1:0], seed_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_SEED;
      wc    <= 1'b0;
      wcnt  <= '0;
      lfsr  <= '0;
    end else begin
      case (state)
        ST_SEED: begin
          if (seed_valid) begin
            wc <= ~wc;
            if (wc) begin
              // An all-zero state would lock the LFSR, so it is forced to 1.
              lfsr  <= (shifted == '0) ? LFSR_LEN'(1) : shifted;
              wcnt  <= CW'(WARMUP);
              state <= ST_WARMUP;
            end else begin
              lfsr <= shifted;
            end
          end
        end
        ST_WARMUP: begin
          lfsr <= stepped;
          wcnt <= wcnt - 1'b1;
          if (wcnt == CW'(1)) state <= ST_RUN;
        end
        ST_RUN: begin
          // A reseed wins over en; the first word lands here, so wc skips to 1.
          if (seed_valid) begin
            lfsr  <= shifted;
            wc    <= 1'b1;
            state <= ST_SEED;
          end else if (en) begin
            lfsr <= stepped;
          end
        end
        default: state <= ST_SEED;
      endcase
    end
  end

  assign rnd_valid  = (state == ST_RUN);
  assign rnd        = (state == ST_RUN) ? lfsr[NRND-1:0] : '0;
  assign seed_ready = (state != ST_WARMUP);
endmodule
